// File: rtl/seq_pkg.sv
// Shared state type and instruction-format helpers for the program sequencer.
package seq_pkg;

  localparam int OPCODE_WIDTH  = 3;
  localparam int OPERAND_WIDTH = 13;
  localparam int INSTR_WIDTH   = OPCODE_WIDTH + OPERAND_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } seq_state_t;

  function automatic logic [OPCODE_WIDTH-1:0] instr_opcode(input logic [INSTR_WIDTH-1:0] instr);
    return instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  endfunction

  function automatic logic [OPERAND_WIDTH-1:0] instr_operand(input logic [INSTR_WIDTH-1:0] instr);
    return instr[OPERAND_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Instruction-memory read port and decoder-facing instruction bus of the sequencer.
interface program_sequencer_if #(
  parameter int ADDR_WIDTH = 8
) ();

  logic                             imem_rd_en;
  logic [ADDR_WIDTH-1:0]            imem_addr;
  logic [seq_pkg::INSTR_WIDTH-1:0]  imem_data;
  logic [seq_pkg::OPCODE_WIDTH-1:0] opcode;
  logic [seq_pkg::OPERAND_WIDTH-1:0] operand;
  logic                             instr_valid;
  logic                             PC_wait;

  modport master (
    output imem_rd_en, imem_addr, opcode, operand, instr_valid,
    input  imem_data, PC_wait
  );

  modport slave (
    input  imem_rd_en, imem_addr, opcode, operand, instr_valid,
    output imem_data, PC_wait
  );

endinterface

// File: rtl/seq_wait_timer.sv
// Counts consecutive WAIT cycles; expired marks the WAIT_TIMEOUT-th cycle in WAIT.
module seq_wait_timer #(
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expired
);

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  // Any cycle outside WAIT clears the count, so every WAIT entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      count_reg <= '0;
    end else if (!expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = active && (count_reg == CW'(WAIT_TIMEOUT - 1));

endmodule

// File: rtl/program_sequencer.sv
// Fetch stage feeding the instruction decoder: PC, sync-read imem fetch, WAIT stall.
// Optional WAIT timeout exit is enabled by defining SEQ_WAIT_TIMEOUT_EN.
module program_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int PROG_LEN   = 256
`ifdef SEQ_WAIT_TIMEOUT_EN
  , parameter int WAIT_TIMEOUT = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ext_trig,
  program_sequencer_if.master   bus,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  running,
  output logic                  loop_done
`ifdef SEQ_WAIT_TIMEOUT_EN
  , output logic                wait_timeout
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_LEN - 1);

  seq_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] exec_addr_reg, exec_addr_next;
  logic                  instr_valid_reg, instr_valid_next;
  logic                  rd_en;
  logic                  timeout_hit;

  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

`ifdef SEQ_WAIT_TIMEOUT_EN
  seq_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (state_reg == WAIT),
    .expired (timeout_hit)
  );

  // Trigger and disable both take precedence, so the pulse only marks a genuine timeout exit.
  assign wait_timeout = (state_reg == WAIT) && en && !ext_trig && timeout_hit;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      exec_addr_reg   <= '0;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      exec_addr_reg   <= exec_addr_next;
      instr_valid_reg <= instr_valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    exec_addr_next   = exec_addr_reg;
    instr_valid_next = 1'b0;
    rd_en            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        rd_en = 1'b1;
        if (!en) begin
          // Resume at the first instruction the decoder has not yet seen.
          state_next = IDLE;
          pc_next    = instr_valid_reg ? wrap_inc(exec_addr_reg) : pc_reg;
        end else if (instr_valid_reg && bus.PC_wait) begin
          // The fetch issued this cycle is dropped; it is refetched on resume.
          state_next = WAIT;
          pc_next    = wrap_inc(exec_addr_reg);
        end else begin
          pc_next          = wrap_inc(pc_reg);
          exec_addr_next   = pc_reg;
          instr_valid_next = 1'b1;
        end
      end
      WAIT: begin
        if (!en) begin
          state_next = IDLE;
        end else if (ext_trig || timeout_hit) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.imem_rd_en  = rd_en;
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.opcode      = instr_valid_reg ? instr_opcode(bus.imem_data) : '0;
  assign bus.operand     = instr_valid_reg ? instr_operand(bus.imem_data) : '0;

  assign pc        = pc_reg;
  assign running   = (state_reg != IDLE);
  assign loop_done = instr_valid_reg && (exec_addr_reg == LAST_ADDR);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: full-length program (A) and a 4-entry wrapping program (B).
module tb_program_sequencer;
  import seq_pkg::*;

  localparam int AW = 8;
  localparam logic [OPCODE_WIDTH-1:0] OP_MAC  = 3'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_SETB = 3'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_WAIT = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          rst_a, en_a, trig_a, running_a, loop_done_a;
  logic [AW-1:0] pc_a;
  logic          rst_b, en_b, trig_b, running_b, loop_done_b;
  logic [AW-1:0] pc_b;
`ifdef SEQ_WAIT_TIMEOUT_EN
  logic          wto_a, wto_b;
`endif

  program_sequencer_if #(.ADDR_WIDTH(AW)) bus_a ();
  program_sequencer_if #(.ADDR_WIDTH(AW)) bus_b ();

  logic [INSTR_WIDTH-1:0] mem_a [2**AW];
  logic [INSTR_WIDTH-1:0] mem_b [2**AW];

  // Sync-read memories; operand holds the word's own address so it identifies what executed.
  always @(posedge clk) if (bus_a.imem_rd_en) bus_a.imem_data <= mem_a[bus_a.imem_addr];
  always @(posedge clk) if (bus_b.imem_rd_en) bus_b.imem_data <= mem_b[bus_b.imem_addr];

  // Decoder model: only the WAIT opcode asks the sequencer to stall.
  assign bus_a.PC_wait = bus_a.instr_valid && (bus_a.opcode == OP_WAIT);
  assign bus_b.PC_wait = bus_b.instr_valid && (bus_b.opcode == OP_WAIT);

  program_sequencer #(
    .ADDR_WIDTH(AW), .PROG_LEN(256)
`ifdef SEQ_WAIT_TIMEOUT_EN
    , .WAIT_TIMEOUT(16)
`endif
  ) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .ext_trig(trig_a), .bus(bus_a.master),
    .pc(pc_a), .running(running_a), .loop_done(loop_done_a)
`ifdef SEQ_WAIT_TIMEOUT_EN
    , .wait_timeout(wto_a)
`endif
  );

  program_sequencer #(
    .ADDR_WIDTH(AW), .PROG_LEN(4)
`ifdef SEQ_WAIT_TIMEOUT_EN
    , .WAIT_TIMEOUT(16)
`endif
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .ext_trig(trig_b), .bus(bus_b.master),
    .pc(pc_b), .running(running_b), .loop_done(loop_done_b)
`ifdef SEQ_WAIT_TIMEOUT_EN
    , .wait_timeout(wto_b)
`endif
  );

  always @(negedge clk) begin
    if (bus_a.instr_valid) $display("A exec addr=%0d opcode=%0d loop_done=%0b", bus_a.operand, bus_a.opcode, loop_done_a);
    if (bus_b.instr_valid) $display("B exec addr=%0d opcode=%0d loop_done=%0b", bus_b.operand, bus_b.opcode, loop_done_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_valid"},   32'(bus_a.instr_valid), 32'd0);
    check({tag, "_rd_en"},   32'(bus_a.imem_rd_en),  32'd0);
    check({tag, "_running"}, 32'(running_a),         32'd0);
    check({tag, "_pc"},      32'(pc_a),              32'd0);
    check({tag, "_loop"},    32'(loop_done_a),       32'd0);
    check({tag, "_opcode"},  32'(bus_a.opcode),      32'd0);
  endtask

  // Bounded search for the cycle where a given address is valid on DUT A.
  task automatic run_to(input logic [OPERAND_WIDTH-1:0] target, input string tag);
    int n = 0;
    while (!(bus_a.instr_valid && bus_a.operand == target) && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(n < 40), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    for (int i = 0; i < 2**AW; i++) begin
      mem_a[i] = {OP_MAC, OPERAND_WIDTH'(i)};
      mem_b[i] = {OP_MAC, OPERAND_WIDTH'(i)};
    end
    mem_a[2] = {OP_SETB, OPERAND_WIDTH'(2)};
    mem_a[5] = {OP_WAIT, OPERAND_WIDTH'(5)};

    rst_a = 1'b1; en_a = 1'b0; trig_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; trig_b = 1'b0;
    step(); step();
    check_reset_a("reset");

    // Fetch from 0 begins the cycle after en; first valid two cycles after en.
    rst_a = 1'b0; en_a = 1'b1;
    step();
    check("t1_rd_en",       32'(bus_a.imem_rd_en),  32'd1);
    check("t1_addr0",       32'(bus_a.imem_addr),   32'd0);
    check("t1_not_yet",     32'(bus_a.instr_valid), 32'd0);
    check("t1_running",     32'(running_a),         32'd1);
    trig_a = 1'b1;  // held through RUN and the PC_wait cycle; must be ignored
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t1_valid%0d", i),   32'(bus_a.instr_valid), 32'd1);
      check($sformatf("t1_operand%0d", i), 32'(bus_a.operand),     32'(i));
      check($sformatf("t1_opcode%0d", i),  32'(bus_a.opcode),      32'((i == 2) ? OP_SETB : OP_MAC));
      check($sformatf("t1_pc%0d", i),      32'(pc_a),              32'(i + 1));
    end
    step();
    check("t2_operand4", 32'(bus_a.operand), 32'd4);
    step();
    check("t2_wait_instr", 32'(bus_a.opcode),  32'(OP_WAIT));
    check("t2_wait_addr",  32'(bus_a.operand), 32'd5);
    step();
    trig_a = 1'b0;
    check("t2_valid_drop", 32'(bus_a.instr_valid), 32'd0);
    check("t2_rd_en_off",  32'(bus_a.imem_rd_en),  32'd0);
    check("t2_pc6",        32'(pc_a),              32'd6);
    check("t3_in_wait",    32'(running_a),         32'd1);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus_a.instr_valid || bus_a.imem_rd_en || !running_a) bad++;
    end
    check("t3_stayed_wait", 32'(bad), 32'd0);

    step();
    trig_a = 1'b1;
    step();
    trig_a = 1'b0;
    check("t2_refetch_rd", 32'(bus_a.imem_rd_en),  32'd1);
    check("t2_refetch6",   32'(bus_a.imem_addr),   32'd6);
    check("t2_trig+1_inv", 32'(bus_a.instr_valid), 32'd0);
    step();
    check("t2_trig+2_val", 32'(bus_a.instr_valid), 32'd1);
    check("t2_trig+2_op6", 32'(bus_a.operand),     32'd6);
    step();
    check("t2_addr6_once", 32'(bus_a.operand),     32'd7);

    // Drop en in the cycle addr 7 executes; resume must start at addr 8.
    en_a = 1'b0;
    step();
    check("t5_idle_valid",   32'(bus_a.instr_valid), 32'd0);
    check("t5_idle_running", 32'(running_a),         32'd0);
    check("t5_idle_rd",      32'(bus_a.imem_rd_en),  32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_a.instr_valid || bus_a.imem_rd_en) bad++;
    end
    check("t5_idle_quiet", 32'(bad), 32'd0);
    en_a = 1'b1;
    step();
    check("t5_refetch8", 32'(bus_a.imem_addr), 32'd8);
    step();
    check("t5_resume_valid", 32'(bus_a.instr_valid), 32'd1);
    check("t5_resume_op8",   32'(bus_a.operand),     32'd8);
    step();
    check("t6_run_op9", 32'(bus_a.operand), 32'd9);

    rst_a = 1'b1;
    step();
    check_reset_a("t6_rst_run");
    rst_a = 1'b0;
    run_to(5, "t6_reach_wait");
    step();
    check("t6_wait_valid", 32'(bus_a.instr_valid), 32'd0);
    check("t6_wait_run",   32'(running_a),         32'd1);
    rst_a = 1'b1;
    step();
    check_reset_a("t6_rst_wait");
    rst_a = 1'b0;

`ifdef SEQ_WAIT_TIMEOUT_EN
    run_to(5, "t6_reach_wait2");
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (wto_a || bus_a.instr_valid) bad++;
    end
    check("t6_no_early_timeout", 32'(bad), 32'd0);
    step();
    check("t6_timeout_pulse", 32'(wto_a), 32'd1);
    step();
    check("t6_timeout_1cyc", 32'(wto_a),           32'd0);
    check("t6_timeout_addr", 32'(bus_a.imem_addr), 32'd6);
    step();
    check("t6_timeout_op6", 32'(bus_a.operand), 32'd6);
`endif

    // PROG_LEN=4: addresses wrap 0..3 and loop_done marks each addr-3 valid cycle.
    rst_b = 1'b0; en_b = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t4_valid%0d", i), 32'(bus_b.instr_valid), 32'd1);
      check($sformatf("t4_addr%0d", i),  32'(bus_b.operand),     32'(i % 4));
      check($sformatf("t4_loop%0d", i),  32'(loop_done_b),       32'((i % 4) == 3));
      check($sformatf("t4_pc%0d", i),    32'(pc_b),              32'((i + 1) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
